// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a valid/ready load handshake and a one-word
// holding buffer, so that consecutive words stream without gaps. Bits advance on bit_en.
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         D,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic                     bit_en,
  output logic                     out,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  shift_q;
  logic [WIDTH-1:0]  hold_q;
  logic              hold_full_q;
  logic [CW-1:0]     cnt_q;
  logic              done_q;

  logic              xfer;
  logic [WIDTH-1:0]  shift_d;

  assign load_ready = ~hold_full_q;
  assign xfer       = load_valid & ~hold_full_q;
  assign shift_d    = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

  assign busy    = (state_q == S_SHIFT);
  assign bit_cnt = cnt_q;
  assign done    = done_q;
  assign out     = (state_q == S_SHIFT) ? (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0])
                                        : IDLE_LEVEL;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (xfer) begin
            shift_q <= D;
            cnt_q   <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Last-bit edge: a pending hold word wins; otherwise a same-edge transfer
          // bypasses hold and lands in the shifter directly.
          if (bit_en && (cnt_q == LAST)) begin
            done_q <= 1'b1;
            cnt_q  <= '0;
            if (hold_full_q) begin
              shift_q     <= hold_q;
              hold_full_q <= 1'b0;
            end else if (xfer) begin
              shift_q <= D;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            if (xfer) begin
              hold_q      <= D;
              hold_full_q <= 1'b1;
            end
            if (bit_en) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a vector table for reset and a single word,
// plus hand-written sequences for streaming, pacing, MSB-first order and abort.
module tb_piso_serializer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  logic [7:0] d0, d1;
  logic       lv0, lv1, be0, be1;
  logic       rdy0, rdy1, out0, out1, busy0, busy1, done0, done1;
  logic [2:0] cnt0, cnt1;

  int checks   = 0;
  int failures = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_lsb (
    .clk(clk), .clr(clr), .D(d0), .load_valid(lv0), .load_ready(rdy0),
    .bit_en(be0), .out(out0), .busy(busy0), .done(done0), .bit_cnt(cnt0)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_msb (
    .clk(clk), .clr(clr), .D(d1), .load_valid(lv1), .load_ready(rdy1),
    .bit_en(be1), .out(out1), .busy(busy1), .done(done1), .bit_cnt(cnt1)
  );

  typedef struct {
    logic       clr;
    logic [7:0] d;
    logic       lv;
    logic       be;
    logic       o;
    logic       b;
    logic       r;
    logic       dn;
    logic [2:0] c;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lsb(input string tag, input logic o, input logic b, input logic r,
                           input logic dn, input logic [2:0] c);
    check({tag, ".out"},     {7'd0, out0},  {7'd0, o});
    check({tag, ".busy"},    {7'd0, busy0}, {7'd0, b});
    check({tag, ".ready"},   {7'd0, rdy0},  {7'd0, r});
    check({tag, ".done"},    {7'd0, done0}, {7'd0, dn});
    check({tag, ".bit_cnt"}, {5'd0, cnt0},  {5'd0, c});
  endtask

  initial begin
    int  pulses;
    int  last_done;
    logic stream [16];
    logic fbits  [8];
    logic mbits  [8];
    logic obits  [8];

    clr = 1'b0; d0 = '0; d1 = '0; lv0 = 1'b0; lv1 = 1'b0; be0 = 1'b0; be1 = 1'b0;

    //            clr   D      lv    be    out   busy  rdy   done  cnt
    tbl[0]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[2]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd6};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd7};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};

    stream = '{0,0,1,1,1,1,0,0, 1,1,0,0,0,0,1,1};
    fbits  = '{0,0,0,0,1,1,1,1};
    mbits  = '{1,1,0,0,0,0,0,1};
    obits  = '{1,0,0,0,0,0,0,0};

    // Reset and a single LSB-first word 8'hA5
    for (int i = 0; i < 12; i++) begin
      clr = tbl[i].clr; d0 = tbl[i].d; lv0 = tbl[i].lv; be0 = tbl[i].be;
      tick();
      check_lsb($sformatf("tbl%0d", i), tbl[i].o, tbl[i].b, tbl[i].r, tbl[i].dn, tbl[i].c);
    end
    check("msb_reset.out",   {7'd0, out1},  8'd1);
    check("msb_reset.ready", {7'd0, rdy1},  8'd1);

    // Back-to-back: 8'h3C then 8'hC3 offered while bit 2 is on the line
    pulses = 0; last_done = -1;
    be0 = 1'b1;
    for (int k = 0; k < 18; k++) begin
      lv0 = (k == 0) || (k == 3);
      d0  = (k == 0) ? 8'h3C : 8'hC3;
      tick();
      if (done0) begin
        if (pulses == 1) check("b2b.done_gap", 8'(k - last_done), 8'd8);
        pulses++;
        last_done = k;
      end
      if (k < 16) begin
        check($sformatf("b2b.out%0d", k),  {7'd0, out0},  {7'd0, stream[k]});
        check($sformatf("b2b.cnt%0d", k),  {5'd0, cnt0},  8'(k % 8));
        check($sformatf("b2b.busy%0d", k), {7'd0, busy0}, 8'd1);
      end else begin
        check($sformatf("b2b.idle_out%0d", k),  {7'd0, out0},  8'd1);
        check($sformatf("b2b.idle_busy%0d", k), {7'd0, busy0}, 8'd0);
      end
      check($sformatf("b2b.ready%0d", k), {7'd0, rdy0}, (k >= 3 && k <= 7) ? 8'd0 : 8'd1);
      check($sformatf("b2b.done%0d", k),  {7'd0, done0}, (k == 8 || k == 16) ? 8'd1 : 8'd0);
    end
    lv0 = 1'b0;
    check("b2b.pulses", 8'(pulses), 8'd2);

    // Paced: bit_en every 4th cycle, 8'hF0
    pulses = 0;
    for (int k = 0; k < 34; k++) begin
      lv0 = (k == 0);
      d0  = 8'hF0;
      be0 = (k > 0) && (k % 4 == 0);
      tick();
      if (done0) pulses++;
      if (k < 32) begin
        check($sformatf("pace.out%0d", k),  {7'd0, out0},  {7'd0, fbits[k/4]});
        check($sformatf("pace.cnt%0d", k),  {5'd0, cnt0},  8'(k / 4));
        check($sformatf("pace.done%0d", k), {7'd0, done0}, 8'd0);
      end else if (k == 32) begin
        check_lsb("pace.end", 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
      end else begin
        check("pace.after.done", {7'd0, done0}, 8'd0);
      end
    end
    lv0 = 1'b0; be0 = 1'b0;
    check("pace.pulses", 8'(pulses), 8'd1);

    // MSB-first instance, 8'hC1
    for (int k = 0; k < 10; k++) begin
      lv1 = (k == 0);
      d1  = 8'hC1;
      be1 = 1'b1;
      tick();
      if (k < 8) begin
        check($sformatf("msb.out%0d", k), {7'd0, out1}, {7'd0, mbits[k]});
        check($sformatf("msb.cnt%0d", k), {5'd0, cnt1}, 8'(k));
      end else begin
        check($sformatf("msb.idle%0d", k), {7'd0, out1}, 8'd1);
        check($sformatf("msb.done%0d", k), {7'd0, done1}, (k == 8) ? 8'd1 : 8'd0);
      end
    end
    lv1 = 1'b0; be1 = 1'b0;

    // Abort with clr while bit_cnt=3 and the hold buffer is full
    be0 = 1'b1; lv0 = 1'b1; d0 = 8'hAA;
    tick();
    d0 = 8'h55;
    tick();
    lv0 = 1'b0;
    tick();
    tick();
    check_lsb("abort.pre", 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_lsb("abort.post", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    tick();
    check_lsb("abort.post2", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);

    // Word 8'h01 after the abort
    for (int k = 0; k < 10; k++) begin
      lv0 = (k == 0);
      d0  = 8'h01;
      tick();
      if (k < 8) begin
        check($sformatf("post.out%0d", k),  {7'd0, out0},  {7'd0, obits[k]});
        check($sformatf("post.cnt%0d", k),  {5'd0, cnt0},  8'(k));
        check($sformatf("post.done%0d", k), {7'd0, done0}, 8'd0);
      end else begin
        check_lsb($sformatf("post.end%0d", k), 1'b1, 1'b0, 1'b1, (k == 8), 3'd0);
      end
    end
    lv0 = 1'b0; be0 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
